mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 32, memory address width.
REQ-002 SHALL have parameter DATA_W, default 32, memory data width.
REQ-003 SHALL have parameter TIMEOUT, default 255, maximum busy cycles before forced completion (range 1..255).
REQ-004 SHALL have port clk  in  1  sole clock, all state updates on rising edge.
REQ-005 SHALL have port rst  in  1  asynchronous, active-high reset.
REQ-006 SHALL have ports ireqF in 1 and iaddrF in ADDR_W: fetch request and address, held stable until ireadyF.
REQ-007 SHALL have ports ireadyF out 1 and instrF out DATA_W: fetch completion pulse and fetch data.
REQ-008 SHALL have ports dreqM in 1, dwriteM in 1, daddrM in ADDR_W and dwdataM in DATA_W: data request, write enable, address and write data, held stable until dreadyM.
REQ-009 SHALL have ports dreadyM out 1 and drdataM out DATA_W: data completion pulse and load data.
REQ-010 SHALL have ports mem_req out 1, mem_we out 1, mem_addr out ADDR_W and mem_wdata out DATA_W: shared single memory port request.
REQ-011 SHALL have ports mem_rdata in DATA_W and mem_ack in 1: memory read data, valid in the cycle mem_ack=1.
REQ-012 SHALL have ports stallF out 1, stallM out 1 and err out 1: fetch stall, memory-stage stall and sticky timeout flag.

Function
REQ-013 SHALL implement FSM states IDLE, IBUSY and DBUSY.
REQ-014 In IDLE, SHALL go to DBUSY if dreqM=1, else to IBUSY if ireqF=1, else stay in IDLE; data has fixed priority.
REQ-015 On each grant, SHALL latch the address, write enable (0 for fetch) and write data of the granted side into port registers.
REQ-016 mem_req SHALL be 1 exactly when state is not IDLE; mem_addr, mem_we and mem_wdata SHALL come from the port registers.
REQ-017 In DBUSY with mem_ack=1, dreadyM SHALL be 1 combinationally in that cycle, with drdataM=mem_rdata (don't-care for writes).
REQ-018 In IBUSY with mem_ack=1, ireadyF SHALL be 1 combinationally in that cycle, with instrF=mem_rdata.
REQ-019 On completion, next state SHALL be the other side's BUSY state if that side's request is 1 in the completion cycle, else IDLE; a completing side SHALL never be re-granted directly.
REQ-020 Minimum latency: request in IDLE at cycle 0 gives mem_req=1 at cycle 1; ready can assert at cycle 1 at the earliest.
REQ-021 Outside their completion cycle, instrF and drdataM SHALL hold the last value returned to that side, held in per-side registers.
REQ-022 stallF SHALL equal ireqF & ~ireadyF; stallM SHALL equal dreqM & ~dreadyM.
REQ-023 A busy counter SHALL clear on every grant and increment each BUSY cycle without mem_ack.
REQ-024 When the busy counter reaches TIMEOUT, SHALL force completion in that cycle: ready=1, returned data all zeros, err set.
REQ-025 err SHALL stay set until reset.
REQ-026 mem_ack while IDLE SHALL be ignored, with no ready and no state change.
REQ-027 Request changes while BUSY SHALL NOT alter the port registers.

Reset
REQ-028 rst=1 SHALL immediately force state IDLE, mem_req=0, port registers, hold registers and busy counter to 0, and err=0.
REQ-029 Under reset, ireadyF, dreadyM, stallF and stallM SHALL reflect reset state: ready=0, stall=request.
REQ-030 Reset during BUSY SHALL abandon the transaction, with no ready pulse afterward.

Structure
REQ-031 State encoding (IDLE=2'b00, IBUSY=2'b01, DBUSY=2'b10) and the TIMEOUT default SHALL live in a shared package/defines file used by the pipeline control blocks.
REQ-032 The busy/timeout counter SHALL be one sub-module, mem_timeout_cnt, with ports clk, rst, clear, enable and expired.
REQ-033 The block SHALL contain no other sub-modules; register helpers are permitted.

Verification
REQ-034 Fetch-only, ireqF=1, iaddrF=0x00400000, memory acks 1 cycle after mem_req: mem_req at cycle 1, ack at cycle 2, ireadyF=1 at cycle 2, instrF=mem_rdata, then IDLE.
REQ-035 Simultaneous ireqF and dreqM (dwriteM=1, daddrM=0x10010000, dwdataM=0xDEADBEEF): DBUSY first with mem_we=1 and those values; on D ack, go directly to IBUSY with mem_we=0.
REQ-036 Stall check, 3-cycle ack latency on a load: stallM=1 for every cycle until the ack cycle, then 0; drdataM then holds the value.
REQ-037 Timeout with TIMEOUT=4 and no ack: ready pulses at the 4th busy cycle, data=0, err=1 stays set through later normal transactions.
REQ-038 Reset mid-transaction, rst asserted in IBUSY before ack: mem_req drops without waiting for a clock edge, no ireadyF; after release, a held ireqF is re-granted from IDLE.

Source files
------------

// File: rtl/mem_arbiter_pkg.sv
// Shared definitions for the memory arbiter: FSM encoding and the timeout default.
package mem_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        IBUSY = 2'b01,
        DBUSY = 2'b10
    } arbState_t;

    localparam int TIMEOUT_DEFAULT = 255;
    localparam int CNT_W           = 8;

endpackage

// File: rtl/mem_timeout_cnt.sv
// Busy-cycle watchdog: reloads on each grant, flags the TIMEOUT-th busy cycle without an ack.
module mem_timeout_cnt
    import mem_arbiter_pkg::*;
#(
    parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    // Counts down the remaining no-ack cycles; terminal count at zero marks expiry.
    localparam logic [CNT_W-1:0] LOAD = CNT_W'(TIMEOUT - 1);

    logic [CNT_W-1:0] remaining;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            remaining <= '0;
        end else if (clear) begin
            remaining <= LOAD;
        end else if (enable && (remaining != '0)) begin
            remaining <= remaining - CNT_W'(1);
        end
    end

    assign expired = enable && (remaining == '0);

endmodule

// File: rtl/mem_arbiter.sv
// Shares one memory port between instruction fetch and data access, data side first,
// with a busy-cycle watchdog that forces completion and latches a sticky error.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ireqF,
    input  logic [ADDR_W-1:0] iaddrF,
    output logic              ireadyF,
    output logic [DATA_W-1:0] instrF,
    input  logic              dreqM,
    input  logic              dwriteM,
    input  logic [ADDR_W-1:0] daddrM,
    input  logic [DATA_W-1:0] dwdataM,
    output logic              dreadyM,
    output logic [DATA_W-1:0] drdataM,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ack,
    output logic              stallF,
    output logic              stallM,
    output logic              err
);

    arbState_t         state;
    logic [ADDR_W-1:0] addrReg;
    logic              weReg;
    logic [DATA_W-1:0] wdataReg;
    logic [DATA_W-1:0] instrHold;
    logic [DATA_W-1:0] dataHold;
    logic              errReg;

    logic              busy;
    logic              expired;
    logic              done;
    logic              grantI;
    logic              grantD;
    logic [DATA_W-1:0] retData;

    assign busy    = (state != IDLE);
    assign done    = busy && (mem_ack || expired);
    assign retData = mem_ack ? mem_rdata : '0;

    assign ireadyF = (state == IBUSY) && done;
    assign dreadyM = (state == DBUSY) && done;

    // A finishing side can only hand over to the other side, never to itself.
    assign grantD = dreqM && ((state == IDLE) || ((state == IBUSY) && done));
    assign grantI = ireqF && (((state == IDLE) && !dreqM) || ((state == DBUSY) && done));

    mem_timeout_cnt #(
        .TIMEOUT(TIMEOUT)
    ) uTimeout (
        .clk    (clk),
        .rst    (rst),
        .clear  (grantI || grantD),
        .enable (busy && !mem_ack),
        .expired(expired)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            addrReg   <= '0;
            weReg     <= 1'b0;
            wdataReg  <= '0;
            instrHold <= '0;
            dataHold  <= '0;
            errReg    <= 1'b0;
        end else begin
            if (grantD) begin
                state    <= DBUSY;
                addrReg  <= daddrM;
                weReg    <= dwriteM;
                wdataReg <= dwdataM;
            end else if (grantI) begin
                state    <= IBUSY;
                addrReg  <= iaddrF;
                weReg    <= 1'b0;
                wdataReg <= '0;
            end else if (done) begin
                state <= IDLE;
            end
            if (ireadyF) instrHold <= retData;
            if (dreadyM) dataHold <= retData;
            if (expired) errReg <= 1'b1;
        end
    end

    assign mem_req   = busy;
    assign mem_we    = weReg;
    assign mem_addr  = addrReg;
    assign mem_wdata = wdataReg;
    assign instrF    = ireadyF ? retData : instrHold;
    assign drdataM   = dreadyM ? retData : dataHold;
    assign stallF    = ireqF && !ireadyF;
    assign stallM    = dreqM && !dreadyM;
    assign err       = errReg;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed vector table, hand-written corner sequences,
// and a randomized run against a transaction-level reference model.
module tb_mem_arbiter;

    localparam int TMO = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        ireqF, dreqM, dwriteM, mem_ack;
    logic [31:0] iaddrF, daddrM, dwdataM, mem_rdata;
    logic        ireadyF, dreadyM, mem_req, mem_we, stallF, stallM, err;
    logic [31:0] instrF, drdataM, mem_addr, mem_wdata;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mem_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(TMO)) dut (
        .clk(clk), .rst(rst),
        .ireqF(ireqF), .iaddrF(iaddrF), .ireadyF(ireadyF), .instrF(instrF),
        .dreqM(dreqM), .dwriteM(dwriteM), .daddrM(daddrM), .dwdataM(dwdataM),
        .dreadyM(dreadyM), .drdataM(drdataM),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_ack(mem_ack),
        .stallF(stallF), .stallM(stallM), .err(err)
    );

    task automatic chk1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic nextCycle();
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic        ireq, dreq, dwrite, ack;
        logic [31:0] rdata;
        logic        eReq, eWe;
        logic [31:0] eAddr, eWdata;
        logic        eIrdy, eDrdy;
        logic [31:0] eInstr;
        logic        eStallF, eStallM;
    } vec_t;

    vec_t vecs[11];

    // Transaction-level reference model: who owns the port and what it carries.
    int          owner;
    int          waited;
    logic [31:0] tAddr, tWdata, lastI, lastD;
    logic        tWe;
    bit          dKnown, errE;
    bit          iPend, dPend;
    logic [31:0] ia, da, dwd;
    logic        dw;

    task automatic grantSide(input int side);
        owner  = side;
        waited = 0;
        tAddr  = (side == 2) ? daddrM : iaddrF;
        tWe    = (side == 2) ? dwriteM : 1'b0;
        tWdata = (side == 2) ? dwdataM : 32'h0;
    endtask

    initial begin
        rst = 1'b1; ireqF = 1'b1; dreqM = 1'b0; dwriteM = 1'b0; mem_ack = 1'b0;
        iaddrF = 32'h0040_0000; daddrM = 32'h1001_0000; dwdataM = 32'hDEAD_BEEF; mem_rdata = '0;

        // Reset state
        @(negedge clk);
        chk1("rst_mem_req", mem_req, 1'b0);
        chk1("rst_ireadyF", ireadyF, 1'b0);
        chk1("rst_dreadyM", dreadyM, 1'b0);
        chk1("rst_stallF", stallF, 1'b1);
        chk1("rst_stallM", stallM, 1'b0);
        chk1("rst_err", err, 1'b0);
        chk32("rst_instrF", instrF, 32'h0);
        chk32("rst_drdataM", drdataM, 32'h0);
        chk32("rst_mem_addr", mem_addr, 32'h0);
        dreqM = 1'b1;
        #1;
        chk1("rst_stallM_req", stallM, 1'b1);
        nextCycle();
        rst = 1'b0; ireqF = 1'b0; dreqM = 1'b0;

        // Fetch-only, then simultaneous requests, then idle ack
        vecs[0]  = '{1,0,0,0,32'h0,        0,0,32'h0,        32'h0,        0,0,32'h0,        1,0};
        vecs[1]  = '{1,0,0,0,32'h0,        1,0,32'h0040_0000,32'h0,        0,0,32'h0,        1,0};
        vecs[2]  = '{1,0,0,1,32'h1111_1111,1,0,32'h0040_0000,32'h0,        1,0,32'h1111_1111,0,0};
        vecs[3]  = '{0,0,0,0,32'h0,        0,0,32'h0040_0000,32'h0,        0,0,32'h1111_1111,0,0};
        vecs[4]  = '{1,1,1,0,32'h0,        0,0,32'h0040_0000,32'h0,        0,0,32'h1111_1111,1,1};
        vecs[5]  = '{1,1,1,0,32'h0,        1,1,32'h1001_0000,32'hDEAD_BEEF,0,0,32'h1111_1111,1,1};
        vecs[6]  = '{1,1,1,1,32'h2222_2222,1,1,32'h1001_0000,32'hDEAD_BEEF,0,1,32'h1111_1111,1,0};
        vecs[7]  = '{1,0,0,0,32'h0,        1,0,32'h0040_0000,32'h0,        0,0,32'h1111_1111,1,0};
        vecs[8]  = '{1,0,0,1,32'h3333_3333,1,0,32'h0040_0000,32'h0,        1,0,32'h3333_3333,0,0};
        vecs[9]  = '{0,0,0,1,32'h4444_4444,0,0,32'h0040_0000,32'h0,        0,0,32'h3333_3333,0,0};
        vecs[10] = '{0,0,0,0,32'h0,        0,0,32'h0040_0000,32'h0,        0,0,32'h3333_3333,0,0};

        for (int i = 0; i < 11; i++) begin
            nextCycle();
            ireqF = vecs[i].ireq; dreqM = vecs[i].dreq; dwriteM = vecs[i].dwrite;
            mem_ack = vecs[i].ack; mem_rdata = vecs[i].rdata;
            @(negedge clk);
            chk1("vec_mem_req", mem_req, vecs[i].eReq);
            chk1("vec_mem_we", mem_we, vecs[i].eWe);
            chk32("vec_mem_addr", mem_addr, vecs[i].eAddr);
            chk32("vec_mem_wdata", mem_wdata, vecs[i].eWdata);
            chk1("vec_ireadyF", ireadyF, vecs[i].eIrdy);
            chk1("vec_dreadyM", dreadyM, vecs[i].eDrdy);
            chk32("vec_instrF", instrF, vecs[i].eInstr);
            chk1("vec_stallF", stallF, vecs[i].eStallF);
            chk1("vec_stallM", stallM, vecs[i].eStallM);
        end

        // Load with ack on the third busy-side cycle
        nextCycle();
        dreqM = 1'b1; dwriteM = 1'b0; daddrM = 32'h1001_0040; mem_ack = 1'b0; ireqF = 1'b0;
        @(negedge clk);
        chk1("ld_stallM_c0", stallM, 1'b1);
        chk1("ld_mem_req_c0", mem_req, 1'b0);
        for (int c = 1; c <= 2; c++) begin
            nextCycle();
            @(negedge clk);
            chk1("ld_stallM_wait", stallM, 1'b1);
            chk1("ld_dreadyM_wait", dreadyM, 1'b0);
            chk1("ld_mem_req_wait", mem_req, 1'b1);
        end
        nextCycle();
        mem_ack = 1'b1; mem_rdata = 32'hCAFE_F00D;
        @(negedge clk);
        chk1("ld_dreadyM_ack", dreadyM, 1'b1);
        chk1("ld_stallM_ack", stallM, 1'b0);
        chk32("ld_drdataM_ack", drdataM, 32'hCAFE_F00D);
        nextCycle();
        dreqM = 1'b0; mem_ack = 1'b0; mem_rdata = 32'h0;
        @(negedge clk);
        chk32("ld_drdataM_hold", drdataM, 32'hCAFE_F00D);
        chk1("ld_mem_req_after", mem_req, 1'b0);

        // Watchdog: no ack, forced completion on the 4th busy cycle
        nextCycle();
        ireqF = 1'b1; mem_rdata = 32'hFFFF_FFFF;
        @(negedge clk);
        for (int c = 1; c <= TMO; c++) begin
            nextCycle();
            @(negedge clk);
            chk1("tmo_ireadyF", ireadyF, (c == TMO));
            chk1("tmo_err_pre", err, 1'b0);
        end
        chk32("tmo_instrF_zero", instrF, 32'h0);
        nextCycle();
        ireqF = 1'b0;
        @(negedge clk);
        chk1("tmo_err_set", err, 1'b1);
        chk1("tmo_mem_req", mem_req, 1'b0);
        nextCycle();
        dreqM = 1'b1; daddrM = 32'h1001_0080;
        nextCycle();
        mem_ack = 1'b1; mem_rdata = 32'h5A5A_A5A5;
        @(negedge clk);
        chk1("tmo_normal_dready", dreadyM, 1'b1);
        nextCycle();
        dreqM = 1'b0; mem_ack = 1'b0;
        @(negedge clk);
        chk1("tmo_err_sticky", err, 1'b1);

        // Reset while a fetch is outstanding
        nextCycle();
        ireqF = 1'b1;
        nextCycle();
        @(negedge clk);
        chk1("mrst_busy", mem_req, 1'b1);
        #1 rst = 1'b1;
        #1;
        chk1("mrst_mem_req_async", mem_req, 1'b0);
        chk1("mrst_ireadyF", ireadyF, 1'b0);
        chk1("mrst_stallF", stallF, 1'b1);
        chk1("mrst_err_clear", err, 1'b0);
        mem_ack = 1'b1;
        #1;
        chk1("mrst_ack_ignored", ireadyF, 1'b0);
        nextCycle();
        rst = 1'b0; mem_ack = 1'b0;
        @(negedge clk);
        chk1("mrst_idle_req", mem_req, 1'b0);
        chk1("mrst_idle_rdy", ireadyF, 1'b0);
        nextCycle();
        @(negedge clk);
        chk1("mrst_regrant", mem_req, 1'b1);
        chk32("mrst_regrant_addr", mem_addr, 32'h0040_0000);
        nextCycle();
        mem_ack = 1'b1; mem_rdata = 32'h7777_0001;
        @(negedge clk);
        chk1("mrst_ready", ireadyF, 1'b1);
        chk32("mrst_instrF", instrF, 32'h7777_0001);

        // Randomized run against the reference model
        nextCycle();
        rst = 1'b1; ireqF = 1'b0; dreqM = 1'b0; mem_ack = 1'b0;
        nextCycle();
        rst = 1'b0;
        owner = 0; waited = 0; tAddr = '0; tWdata = '0; tWe = 1'b0;
        lastI = '0; lastD = '0; dKnown = 1'b1; errE = 1'b0;
        iPend = 1'b0; dPend = 1'b0; ia = '0; da = '0; dwd = '0; dw = 1'b0;

        for (int n = 0; n < 3000; n++) begin
            logic        completing, eI, eD;
            logic [31:0] ret;
            nextCycle();
            if (!iPend && ($urandom_range(2, 0) == 0)) begin
                iPend = 1'b1; ia = $urandom;
            end
            if (!dPend && ($urandom_range(2, 0) == 0)) begin
                dPend = 1'b1; da = $urandom; dwd = $urandom; dw = ($urandom_range(1, 0) == 1);
            end
            ireqF = iPend; iaddrF = ia;
            dreqM = dPend; daddrM = da; dwdataM = dwd; dwriteM = dw;
            mem_ack = (owner != 0) ? ($urandom_range(1, 0) == 1) : ($urandom_range(7, 0) == 0);
            mem_rdata = $urandom;
            @(negedge clk);

            completing = (owner != 0) && (mem_ack || (waited + 1 >= TMO));
            ret = mem_ack ? mem_rdata : 32'h0;
            eI = completing && (owner == 1);
            eD = completing && (owner == 2);

            chk1("rnd_mem_req", mem_req, (owner != 0));
            if (owner != 0) begin
                chk32("rnd_mem_addr", mem_addr, tAddr);
                chk1("rnd_mem_we", mem_we, tWe);
                chk32("rnd_mem_wdata", mem_wdata, tWdata);
            end
            chk1("rnd_ireadyF", ireadyF, eI);
            chk1("rnd_dreadyM", dreadyM, eD);
            chk32("rnd_instrF", instrF, eI ? ret : lastI);
            if (eD && !tWe) chk32("rnd_drdataM", drdataM, ret);
            else if (!eD && dKnown) chk32("rnd_drdataM_hold", drdataM, lastD);
            chk1("rnd_stallF", stallF, ireqF && !eI);
            chk1("rnd_stallM", stallM, dreqM && !eD);
            chk1("rnd_err", err, errE);

            if (owner == 0) begin
                if (dreqM) grantSide(2);
                else if (ireqF) grantSide(1);
            end else if (completing) begin
                if (!mem_ack) errE = 1'b1;
                if (owner == 1) begin
                    lastI = ret;
                    if (dreqM) grantSide(2); else owner = 0;
                end else begin
                    lastD = ret; dKnown = !tWe;
                    if (ireqF) grantSide(1); else owner = 0;
                end
            end else begin
                waited++;
            end
            if (eI) iPend = 1'b0;
            if (eD) dPend = 1'b0;
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
